// File: rtl/n_bit_ripple_carry_adder.sv
// Registered n-bit unsigned adder built from a ripple chain of one-bit full adders.
// total carries the (n+1)-bit exact sum one clock after A/B are sampled.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic axb;

  assign axb    = a_i ^ b_i;
  assign sum_o  = axb ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & axb);

endmodule

module n_bit_ripple_carry_adder #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n:0]   total
);

  logic [n:0]   carry;
  logic [n-1:0] sum;
  logic [n:0]   total_d;
  logic [n:0]   total_q;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < n; i++) begin : g_bit
    full_adder u_fa (
      .a_i    (A[i]),
      .b_i    (B[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum[i]),
      .cout_o (carry[i+1])
    );
  end

  // The final carry becomes the MSB, so the result is never truncated.
  assign total_d = {carry[n], sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;

endmodule

// File: tb/tb_n_bit_ripple_carry_adder.sv
// Directed vectors plus a random reference comparison for the registered ripple adder,
// covering widths 1, 8 and 16.

module tb_n_bit_ripple_carry_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a8, b8;
  logic [8:0]  t8;
  logic        a1, b1;
  logic [1:0]  t1;
  logic [15:0] a16, b16;
  logic [16:0] t16;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  n_bit_ripple_carry_adder #(.n(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .A     (a8),
    .B     (b8),
    .total (t8)
  );

  n_bit_ripple_carry_adder #(.n(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .A     (a1),
    .B     (b1),
    .total (t1)
  );

  n_bit_ripple_carry_adder #(.n(16)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .A     (a16),
    .B     (b16),
    .total (t16)
  );

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp_r;

    vecs[0] = '{a: 8'h30, b: 8'h05, exp: 9'h035, name: "sum_30_05"};
    vecs[1] = '{a: 8'h47, b: 8'h70, exp: 9'h0B7, name: "sum_47_70"};
    vecs[2] = '{a: 8'h40, b: 8'h77, exp: 9'h0B7, name: "sum_40_77"};
    vecs[3] = '{a: 8'h14, b: 8'h42, exp: 9'h056, name: "sum_14_42"};
    vecs[4] = '{a: 8'hFF, b: 8'h01, exp: 9'h100, name: "ripple_FF_01"};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, exp: 9'h1FE, name: "ripple_FF_FF"};
    vecs[6] = '{a: 8'h00, b: 8'h00, exp: 9'h000, name: "zero_00_00"};

    // Reset for two edges with all-ones operands on every instance.
    rst = 1'b1;
    a8  = 8'hFF;   b8  = 8'hFF;
    a1  = 1'b1;    b1  = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF;
    edge_sample();
    chk("reset_edge1_n8", {8'h0, t8}, 17'h0);
    edge_sample();
    chk("reset_n8", {8'h0, t8}, 17'h0);
    chk("reset_n1", {15'h0, t1}, 17'h0);
    chk("reset_n16", t16, 17'h0);

    // Back-to-back vectors; the first one is also the first post-reset load.
    rst = 1'b0;
    a8  = vecs[0].a; b8 = vecs[0].b;
    a1  = 1'b1;      b1 = 1'b1;
    a16 = 16'hFFFF;  b16 = 16'h0001;
    for (int i = 0; i < 7; i++) begin
      edge_sample();
      chk(vecs[i].name, {8'h0, t8}, {8'h0, vecs[i].exp});
      if (i == 0) begin
        chk("n1_1_plus_1", {15'h0, t1}, 17'h2);
        chk("n16_FFFF_plus_1", t16, 17'h10000);
      end
      if (i + 1 < 7) begin
        a8 = vecs[i+1].a;
        b8 = vecs[i+1].b;
      end
    end

    // Mid-stream reset discards the result pending on the same edge.
    a8 = 8'h80; b8 = 8'h80; rst = 1'b1;
    edge_sample();
    chk("midreset_discard", {8'h0, t8}, 17'h0);
    rst = 1'b0;
    edge_sample();
    chk("midreset_recover", {8'h0, t8}, 17'h100);

    // Hold: operands changing between edges must not disturb the register.
    a8 = 8'h12; b8 = 8'h34;
    edge_sample();
    chk("hold_load", {8'h0, t8}, 17'h046);
    a8 = 8'hF0; b8 = 8'h20;
    #2;
    chk("hold_between_edges_a", {8'h0, t8}, 17'h046);
    a8 = 8'h0F; b8 = 8'hF1;
    #1;
    chk("hold_between_edges_b", {8'h0, t8}, 17'h046);
    edge_sample();
    chk("hold_next_edge", {8'h0, t8}, 17'h100);

    // Random operands against a reference sum, one per cycle.
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < 1000; i++) begin
      exp_r = {1'b0, a8} + {1'b0, b8};
      edge_sample();
      chk("random_n8", {8'h0, t8}, {8'h0, exp_r});
      a8 = 8'($urandom);
      b8 = 8'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
